// File: rtl/zynq_hp_pkg.sv
// Shared types and AXI constants for the Zynq HP burst master family.
// Also holds the 4 KB boundary helper used by the burst splitter.
package zynq_hp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_DONE
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_CACHE      = 4'b0011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Beats that fit between addr and the next 4 KB page boundary.
   function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo, input int size_log2);
      logic [12:0] bytes_left;
      bytes_left = 13'h1000 - {1'b0, addr_lo};
      return bytes_left >> size_log2;
   endfunction

endpackage

// File: rtl/zynq_hp_burst_splitter.sv
// Address / remaining-beat counters and burst sizing: each burst is the
// minimum of what is left, the max burst length and the room to 4 KB.
module zynq_hp_burst_splitter
   import zynq_hp_pkg::*;
#(
   parameter int addr_width_p    = 32,
   parameter int beats_width_p   = 16,
   parameter int size_log2_p     = 3,
   parameter int max_burst_len_p = 16
) (
   input  logic                     clk_i,
   input  logic                     load_i,
   input  logic [addr_width_p-1:0]  load_addr_i,
   input  logic [beats_width_p-1:0] load_beats_i,
   input  logic                     advance_i,
   output logic [addr_width_p-1:0]  addr_o,
   output logic [8:0]               burst_beats_o,
   output logic                     last_burst_o
);

   localparam int cw_lp = (beats_width_p > 13) ? beats_width_p : 13;
   localparam logic [addr_width_p-1:0] align_mask_lp = {addr_width_p{1'b1}} << size_log2_p;

   logic [addr_width_p-1:0]  addr_q;
   logic [beats_width_p-1:0] remaining_q;
   logic [cw_lp-1:0]         rem_ext;
   logic [cw_lp-1:0]         to_4k;
   logic [cw_lp-1:0]         sized;

   always_comb begin
      rem_ext = cw_lp'(remaining_q);
      to_4k   = cw_lp'(beats_to_4k(addr_q[11:0], size_log2_p));
      sized   = rem_ext;
      if (cw_lp'(max_burst_len_p) < sized) sized = cw_lp'(max_burst_len_p);
      if (to_4k < sized) sized = to_4k;
      burst_beats_o = 9'(sized);
      last_burst_o  = (rem_ext == sized);
   end

   // Counters carry no control meaning outside a transfer, so they are not reset.
   always_ff @(posedge clk_i) begin
      if (load_i) begin
         addr_q      <= load_addr_i & align_mask_lp;
         remaining_q <= load_beats_i;
      end else if (advance_i) begin
         addr_q      <= addr_q + (addr_width_p'(burst_beats_o) << size_log2_p);
         remaining_q <= remaining_q - beats_width_p'(burst_beats_o);
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/zynq_hp_burst_master.sv
// AXI4 HP-port burst master: one command at a time, split into INCR bursts,
// with combinational write/read stream pass-through and a sticky error flag.
module zynq_hp_burst_master
   import zynq_hp_pkg::*;
#(
   parameter int axi_data_width_p = 64,
   parameter int axi_addr_width_p = 32,
   parameter int axi_id_width_p   = 6,
   parameter int max_burst_len_p  = 16,
   parameter int beats_width_p    = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          cmd_v_i,
   output logic                          cmd_ready_o,
   input  logic                          cmd_write_i,
   input  logic [axi_addr_width_p-1:0]   cmd_addr_i,
   input  logic [beats_width_p-1:0]      cmd_beats_i,
   input  logic [axi_data_width_p-1:0]   wdata_i,
   input  logic                          wdata_v_i,
   output logic                          wdata_ready_o,
   output logic [axi_data_width_p-1:0]   rdata_o,
   output logic                          rdata_v_o,
   input  logic                          rdata_ready_i,
   output logic                          done_v_o,
   output logic                          done_err_o,
   output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
   output logic [7:0]                    m_axi_awlen_o,
   output logic [2:0]                    m_axi_awsize_o,
   output logic [1:0]                    m_axi_awburst_o,
   output logic                          m_axi_awvalid_o,
   input  logic                          m_axi_awready_i,
   output logic [axi_data_width_p-1:0]   m_axi_wdata_o,
   output logic [axi_data_width_p/8-1:0] m_axi_wstrb_o,
   output logic                          m_axi_wlast_o,
   output logic                          m_axi_wvalid_o,
   input  logic                          m_axi_wready_i,
   input  logic                          m_axi_bvalid_i,
   input  logic [1:0]                    m_axi_bresp_i,
   output logic                          m_axi_bready_o,
   output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
   output logic [7:0]                    m_axi_arlen_o,
   output logic [2:0]                    m_axi_arsize_o,
   output logic [1:0]                    m_axi_arburst_o,
   output logic                          m_axi_arvalid_o,
   input  logic                          m_axi_arready_i,
   input  logic [axi_data_width_p-1:0]   m_axi_rdata_i,
   input  logic [1:0]                    m_axi_rresp_i,
   input  logic                          m_axi_rlast_i,
   input  logic                          m_axi_rvalid_i,
   output logic                          m_axi_rready_o,
   output logic [axi_id_width_p-1:0]     m_axi_awid_o,
   output logic                          m_axi_awlock_o,
   output logic [3:0]                    m_axi_awcache_o,
   output logic [2:0]                    m_axi_awprot_o,
   output logic [3:0]                    m_axi_awqos_o,
   output logic [axi_id_width_p-1:0]     m_axi_arid_o,
   output logic                          m_axi_arlock_o,
   output logic [3:0]                    m_axi_arcache_o,
   output logic [2:0]                    m_axi_arprot_o,
   output logic [3:0]                    m_axi_arqos_o,
   output logic [axi_id_width_p-1:0]     m_axi_wid_o
);

   localparam int size_log2_lp = $clog2(axi_data_width_p / 8);

   state_e      state_q, state_n;
   logic        err_q, err_n;
   logic        write_q;
   logic [8:0]  beat_q, beat_n;
   logic        load, advance, beat_last, last_burst;
   logic [8:0]  burst_beats;
   logic [axi_addr_width_p-1:0] burst_addr;

   // Burst end is taken from the internal beat count; rlast is ignored.
   logic unused_rlast;
   assign unused_rlast = m_axi_rlast_i;

   zynq_hp_burst_splitter #(
      .addr_width_p    (axi_addr_width_p),
      .beats_width_p   (beats_width_p),
      .size_log2_p     (size_log2_lp),
      .max_burst_len_p (max_burst_len_p)
   ) splitter (
      .clk_i         (clk_i),
      .load_i        (load),
      .load_addr_i   (cmd_addr_i),
      .load_beats_i  (cmd_beats_i),
      .advance_i     (advance),
      .addr_o        (burst_addr),
      .burst_beats_o (burst_beats),
      .last_burst_o  (last_burst)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         err_q   <= err_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load) write_q <= cmd_write_i;
      beat_q <= beat_n;
   end

   always_comb begin
      state_n         = state_q;
      err_n           = err_q;
      beat_n          = beat_q;
      load            = 1'b0;
      advance         = 1'b0;
      cmd_ready_o     = 1'b0;
      m_axi_awvalid_o = 1'b0;
      m_axi_arvalid_o = 1'b0;
      m_axi_wvalid_o  = 1'b0;
      m_axi_wlast_o   = 1'b0;
      wdata_ready_o   = 1'b0;
      m_axi_bready_o  = 1'b0;
      rdata_v_o       = 1'b0;
      m_axi_rready_o  = 1'b0;
      done_v_o        = 1'b0;
      beat_last       = (beat_q == burst_beats - 9'd1);
      case (state_q)
         ST_IDLE: begin
            cmd_ready_o = ~reset_i;
            if (cmd_v_i) begin
               load    = 1'b1;
               err_n   = 1'b0;
               state_n = (cmd_beats_i == '0) ? ST_DONE : ST_ADDR;
            end
         end
         ST_ADDR: begin
            m_axi_awvalid_o = write_q;
            m_axi_arvalid_o = ~write_q;
            if (write_q ? m_axi_awready_i : m_axi_arready_i) begin
               state_n = ST_DATA;
               beat_n  = 9'd0;
            end
         end
         ST_DATA: begin
            if (write_q) begin
               m_axi_wvalid_o = wdata_v_i;
               wdata_ready_o  = m_axi_wready_i;
               m_axi_wlast_o  = beat_last;
               if (wdata_v_i && m_axi_wready_i) begin
                  if (beat_last) state_n = ST_RESP;
                  else           beat_n  = beat_q + 9'd1;
               end
            end else begin
               rdata_v_o      = m_axi_rvalid_i;
               m_axi_rready_o = rdata_ready_i;
               if (m_axi_rvalid_i && rdata_ready_i) begin
                  err_n = err_q | (m_axi_rresp_i != AXI_RESP_OKAY);
                  if (beat_last) begin
                     advance = 1'b1;
                     state_n = last_burst ? ST_DONE : ST_ADDR;
                  end else begin
                     beat_n = beat_q + 9'd1;
                  end
               end
            end
         end
         ST_RESP: begin
            m_axi_bready_o = 1'b1;
            if (m_axi_bvalid_i) begin
               err_n   = err_q | (m_axi_bresp_i != AXI_RESP_OKAY);
               advance = 1'b1;
               state_n = last_burst ? ST_DONE : ST_ADDR;
            end
         end
         ST_DONE: begin
            done_v_o = 1'b1;
            state_n  = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign done_err_o      = err_q;
   assign m_axi_wdata_o   = wdata_i;
   assign rdata_o         = m_axi_rdata_i;
   assign m_axi_wstrb_o   = {(axi_data_width_p/8){1'b1}};
   assign m_axi_awaddr_o  = burst_addr;
   assign m_axi_araddr_o  = burst_addr;
   assign m_axi_awlen_o   = 8'(burst_beats - 9'd1);
   assign m_axi_arlen_o   = 8'(burst_beats - 9'd1);
   assign m_axi_awsize_o  = 3'(size_log2_lp);
   assign m_axi_arsize_o  = 3'(size_log2_lp);
   assign m_axi_awburst_o = AXI_BURST_INCR;
   assign m_axi_arburst_o = AXI_BURST_INCR;
   assign m_axi_awid_o    = '0;
   assign m_axi_arid_o    = '0;
   assign m_axi_wid_o     = '0;
   assign m_axi_awlock_o  = 1'b0;
   assign m_axi_arlock_o  = 1'b0;
   assign m_axi_awcache_o = AXI_CACHE;
   assign m_axi_arcache_o = AXI_CACHE;
   assign m_axi_awprot_o  = 3'b000;
   assign m_axi_arprot_o  = 3'b000;
   assign m_axi_awqos_o   = 4'b0000;
   assign m_axi_arqos_o   = 4'b0000;

endmodule
